// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 BIST sequencer.
//   state_t   : sequencer states IDLE -> INIT -> RUN -> DONE
//   LFSR_TAPS : feedback taps of the 8-bit pattern LFSR (bits 7,5,4,3)
//   MISR_TAPS : feedback taps of the 16-bit signature MISR (bits 15,13,12,10)
//   INIT_VEC  : {G3,G2,G1,G0} flush vector, forces s27 into (G5,G6,G7)=(1,0,0)
//   SIG_W     : signature width
package s27_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0]  LFSR_TAPS = 8'hB8;
  localparam logic [15:0] MISR_TAPS = 16'hB400;
  localparam logic [3:0]  INIT_VEC  = 4'b0111;
  localparam int          SIG_W     = 16;

  // Fibonacci left shift; feedback is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/s27_bist_ctrl_if.sv
// Tester-side bundle between the BIST sequencer and the s27 test wrapper.
//   start      : level request to begin a test (seen only in IDLE/DONE)
//   golden_sig : expected signature
//   G17        : s27 response bit
//   G0..G3     : registered s27 stimulus
//   busy/done  : sequencer phase flags
//   pass       : signature matched golden_sig (valid while done)
//   signature  : current MISR contents
// slave is the sequencer side; master is the wrapper/tester side.
interface s27_bist_ctrl_if;
  import s27_bist_pkg::*;

  logic             start;
  logic [SIG_W-1:0] golden_sig;
  logic             G17;
  logic             G0;
  logic             G1;
  logic             G2;
  logic             G3;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;

  modport master (
    output start, golden_sig, G17,
    input  G0, G1, G2, G3, busy, done, pass, signature
  );

  modport slave (
    input  start, golden_sig, G17,
    output G0, G1, G2, G3, busy, done, pass, signature
  );

endinterface

// File: rtl/bist_misr.sv
// Generic serial-input MISR.
//   clk, rst : clock, synchronous active-high reset (clears the register)
//   i_clr    : synchronous clear, same effect as reset
//   i_en     : absorb i_din this cycle
//   i_din    : serial response bit, XORed into bit 0
//   o_sig    : current register value
//   o_next   : value the register takes on the next enabled edge
module bist_misr #(
  parameter int                DATA_W = 16,
  parameter logic [DATA_W-1:0] TAPS   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_din,
  output logic [DATA_W-1:0] o_sig,
  output logic [DATA_W-1:0] o_next
);

  logic [DATA_W-1:0] r_sig;
  logic [DATA_W-1:0] w_next;

  assign w_next = {r_sig[DATA_W-2:0], ^(r_sig & TAPS)} ^ {{(DATA_W-1){1'b0}}, i_din};

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig  = r_sig;
  assign o_next = w_next;

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST sequencer for the s27 benchmark: flushes s27 with INIT_VEC, applies
// PAT_CYCLES LFSR vectors on G0..G3, compacts G17 into a MISR and compares the
// final signature against golden_sig.
//   CK, RST : shared clock, synchronous active-high reset
//   bus     : s27_bist_ctrl_if.slave (start, golden_sig, G17 in;
//             G0..G3, busy, done, pass, signature out)
// Capture timing: the vector registered at edge k feeds s27 combinationally and
// its G17 is absorbed at edge k+1, so the final vector is held through the last
// capture edge and then stays on G0..G3 in DONE.
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter int         PAT_CYCLES  = 64,
  parameter int         INIT_CYCLES = 2,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic           CK,
  input  logic           RST,
  s27_bist_ctrl_if.slave bus
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int PAT_W  = $clog2(PAT_CYCLES + 1);

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(PAT_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_lfsr;
  logic [INIT_W-1:0] r_init_cnt;
  logic [PAT_W-1:0]  r_pat_cnt;
  logic [3:0]        r_vec;
  logic              r_pass;

  logic              w_begin;
  logic              w_init_inc;
  logic              w_init_exit;
  logic              w_capture;
  logic              w_last;
  logic [SIG_W-1:0]  w_sig;
  logic [SIG_W-1:0]  w_sig_nxt;

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_begin     = 1'b0;
    w_init_inc  = 1'b0;
    w_init_exit = 1'b0;
    w_capture   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_begin     = 1'b1;
          w_state_nxt = INIT;
        end
      end
      INIT: begin
        if (r_init_cnt == INIT_LAST) begin
          w_init_exit = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_init_inc = 1'b1;
        end
      end
      RUN: begin
        w_capture = 1'b1;
        if (r_pat_cnt == PAT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stage p0: stimulus register, pattern LFSR, phase counters, verdict.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_lfsr     <= SEED;
      r_init_cnt <= '0;
      r_pat_cnt  <= '0;
      r_vec      <= '0;
      r_pass     <= 1'b0;
    end else begin
      if (w_begin) begin
        r_lfsr     <= SEED;
        r_init_cnt <= '0;
        r_pat_cnt  <= '0;
        r_vec      <= INIT_VEC;
        r_pass     <= 1'b0;
      end
      if (w_init_inc) begin
        r_init_cnt <= r_init_cnt + INIT_W'(1);
      end
      // A new vector goes out on INIT exit and on every capture but the last.
      if (w_init_exit || (w_capture && !w_last)) begin
        r_vec  <= r_lfsr[3:0];
        r_lfsr <= lfsr_next(r_lfsr);
      end
      if (w_capture) begin
        r_pat_cnt <= r_pat_cnt + PAT_W'(1);
      end
      // Compare against the value the MISR is about to take, so pass is
      // valid in the same cycle done rises.
      if (w_last) begin
        r_pass <= (w_sig_nxt == bus.golden_sig);
      end
    end
  end

  bist_misr #(
    .DATA_W (SIG_W),
    .TAPS   (MISR_TAPS)
  ) u_misr (
    .clk    (CK),
    .rst    (RST),
    .i_clr  (w_begin),
    .i_en   (w_capture),
    .i_din  (bus.G17),
    .o_sig  (w_sig),
    .o_next (w_sig_nxt)
  );

  assign bus.G0        = r_vec[0];
  assign bus.G1        = r_vec[1];
  assign bus.G2        = r_vec[2];
  assign bus.G3        = r_vec[3];
  assign bus.busy      = (r_state == INIT) || (r_state == RUN);
  assign bus.done      = (r_state == DONE);
  assign bus.pass      = r_pass;
  assign bus.signature = w_sig;

endmodule
